// File: rtl/ysyx_24070016_lsu_pkg.sv
// Shared definitions for the ysyx_24070016 load/store unit.
//   lsu_state_e : two-bit FSM state encoding (IDLE, REQ, WAIT, DONE)
//   LSU_*       : funct3 access-size encodings carried on in_mem_size
package ysyx_24070016_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/ysyx_24070016_lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   Store side: st_off, st_size, st_data -> st_wmask, st_wdata, misalign
//   Load side : ld_off, ld_size, ld_rdata -> ld_ext (sign/zero extended)
// Halfwords use offset o&2 and words offset 0, so misaligned low address
// bits are truncated. With YSYX_24070016_LSU_MISALIGN_CHECK_EN defined,
// misalign flags halfword/word accesses whose low bits are not aligned;
// otherwise it is tied 0.
module ysyx_24070016_lsu_align
  import ysyx_24070016_lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata,
  output logic        misalign,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_size,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_ext
);

  logic [1:0]  ld_eff;
  logic [31:0] sh;

  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      LSU_B, LSU_BU: begin
        st_wmask = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      LSU_H, LSU_HU: begin
        st_wmask = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef YSYX_24070016_LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (st_size)
      LSU_B, LSU_BU: misalign = 1'b0;
      LSU_H, LSU_HU: misalign = st_off[0];
      default:       misalign = (st_off != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (ld_size)
      LSU_B, LSU_BU: ld_eff = ld_off;
      LSU_H, LSU_HU: ld_eff = {ld_off[1], 1'b0};
      default:       ld_eff = 2'b00;
    endcase
    sh = ld_rdata >> {ld_eff, 3'b000};
    case (ld_size)
      LSU_B:   ld_ext = {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  ld_ext = {24'h0, sh[7:0]};
      LSU_H:   ld_ext = {{16{sh[15]}}, sh[15:0]};
      LSU_HU:  ld_ext = {16'h0, sh[15:0]};
      LSU_W:   ld_ext = sh;
      default: ld_ext = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Load/store stage of the ysyx_24070016 core.
// Accepts one execute beat at a time (in_valid/in_ready), performs a single
// memory request/response for loads and stores, and emits one write-back beat
// (out_valid/out_ready). Every output is a flop except in_ready, which is
// decoded from the state register.
//   in_*      : execute-stage beat (pc, result/address, store data, mem ctrl, rd)
//   out_*     : write-back beat (pc, rd, rd_wen, wdata)
//   mem_req_* : word-aligned request with byte-lane mask and shifted data
//   mem_rsp_* : one response per accepted request
//   lsu_misalign : pulse on a dropped misaligned access when
//                  YSYX_24070016_LSU_MISALIGN_CHECK_EN is defined, else 0
module ysyx_24070016_lsu
  import ysyx_24070016_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_en,
  input  logic        in_mem_wen,
  input  logic [2:0]  in_mem_size,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        lsu_misalign
);

  lsu_state_e  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_wen_q, out_rd_wen_d;
  logic [31:0] out_wdata_q, out_wdata_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wmask_q, req_wmask_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        misalign_q, misalign_d;

  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic        st_misalign;
  logic [31:0] ld_ext;

  // Store lanes come from the incoming beat; load lanes from the latched beat.
  ysyx_24070016_lsu_align u_align (
    .st_off   (in_result[1:0]),
    .st_size  (in_mem_size),
    .st_data  (in_store_data),
    .st_wmask (st_wmask),
    .st_wdata (st_wdata),
    .misalign (st_misalign),
    .ld_off   (off_q),
    .ld_size  (size_q),
    .ld_rdata (mem_rsp_rdata),
    .ld_ext   (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_rd_d     = out_rd_q;
    out_rd_wen_d = out_rd_wen_q;
    out_wdata_d  = out_wdata_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_wen_d    = req_wen_q;
    req_wdata_d  = req_wdata_q;
    req_wmask_d  = req_wmask_q;
    off_d        = off_q;
    size_d       = size_q;
    misalign_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          out_pc_d     = in_pc;
          out_rd_d     = in_rd;
          out_rd_wen_d = in_rd_wen & ~(in_mem_en & in_mem_wen);
          out_wdata_d  = in_result;
          off_d        = in_result[1:0];
          size_d       = in_mem_size;
          if (in_mem_en && st_misalign) begin
            // Dropped access: no memory traffic, no register write.
            out_rd_wen_d = 1'b0;
            out_wdata_d  = 32'h0;
            misalign_d   = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end else if (in_mem_en) begin
            req_valid_d  = 1'b1;
            req_addr_d   = {in_result[31:2], 2'b00};
            req_wen_d    = in_mem_wen;
            req_wdata_d  = in_mem_wen ? st_wdata : 32'h0;
            req_wmask_d  = in_mem_wen ? st_wmask : 4'b0000;
            state_d      = S_REQ;
          end else begin
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_REQ: begin
        // A response arriving in this cycle is illegal and ignored.
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (!req_wen_q) out_wdata_d = ld_ext;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_rd_q     <= 5'h0;
      out_rd_wen_q <= 1'b0;
      out_wdata_q  <= 32'h0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= 32'h0;
      req_wen_q    <= 1'b0;
      req_wdata_q  <= 32'h0;
      req_wmask_q  <= 4'h0;
      off_q        <= 2'b00;
      size_q       <= 3'b000;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_rd_q     <= out_rd_d;
      out_rd_wen_q <= out_rd_wen_d;
      out_wdata_q  <= out_wdata_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_wen_q    <= req_wen_d;
      req_wdata_q  <= req_wdata_d;
      req_wmask_q  <= req_wmask_d;
      off_q        <= off_d;
      size_q       <= size_d;
      misalign_q   <= misalign_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_rd        = out_rd_q;
  assign out_rd_wen    = out_rd_wen_q;
  assign out_wdata     = out_wdata_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign lsu_misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
module tb_ysyx_24070016_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_result, in_store_data;
  logic        in_mem_en, in_mem_wen;
  logic [2:0]  in_mem_size;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_wdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        lsu_misalign;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24070016_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_result(in_result), .in_store_data(in_store_data),
    .in_mem_en(in_mem_en), .in_mem_wen(in_mem_wen), .in_mem_size(in_mem_size),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_wdata(out_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .lsu_misalign(lsu_misalign)
  );

  typedef struct {
    logic [31:0] pc, result, sd, rdata;
    logic        mem_en, wen, rd_wen;
    logic [2:0]  msize;
    logic [4:0]  rd;
    bit          exp_mem;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic        exp_rd_wen;
    logic [31:0] exp_out;
    bit          chk_out;
    logic        exp_mis;
    int          req_stall, rsp_dly, out_stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lane/extension rules computed byte by byte with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    int o, nb, eff;
    bit sgn, mis;
    longint val;
    logic [31:0] w;
    o = int'(v.result[1:0]);
    case (v.msize)
      3'd0: begin nb = 1; sgn = 1; end
      3'd4: begin nb = 1; sgn = 0; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd5: begin nb = 2; sgn = 0; end
      default: begin nb = 4; sgn = 0; end
    endcase
`ifdef YSYX_24070016_LSU_MISALIGN_CHECK_EN
    mis = v.mem_en && ((nb == 2 && (o % 2) == 1) || (nb == 4 && o != 0));
`else
    mis = 0;
`endif
    eff = (nb == 1) ? o : (nb == 2) ? (o / 2) * 2 : 0;
    v.exp_mis    = mis;
    v.exp_mem    = v.mem_en && !mis;
    v.exp_addr   = v.result & 32'hFFFF_FFFC;
    v.exp_wmask  = 4'((((1 << nb) - 1) << eff) & 15);
    for (int i = 0; i < 4; i++) begin
      w = v.sd >> (8 * (i % nb));
      v.exp_wdata[8*i +: 8] = w[7:0];
    end
    if (!v.wen) v.exp_wmask = 4'b0000;
    v.exp_rd_wen = v.rd_wen && !(v.mem_en && v.wen) && !mis;
    val = longint'(v.rdata >> (8 * eff));
    if (nb < 4) begin
      val = val % (longint'(1) << (8 * nb));
      if (sgn && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
    end
    if (mis)              begin v.exp_out = 32'h0;       v.chk_out = 1; end
    else if (!v.mem_en)   begin v.exp_out = v.result;    v.chk_out = 1; end
    else if (!v.wen)      begin v.exp_out = val[31:0];   v.chk_out = 1; end
    else                  begin v.exp_out = 32'h0;       v.chk_out = 0; end
    return v;
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, result, sd, rdata,
                              input logic mem_en, wen, input logic [2:0] msize,
                              input logic [4:0] rd, input logic rd_wen,
                              input bit exp_mem, input logic [31:0] exp_addr,
                              input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                              input logic exp_rd_wen, input logic [31:0] exp_out,
                              input bit chk_out, input logic exp_mis,
                              input int rs, rdl, os);
    vec_t v;
    v.pc = pc; v.result = result; v.sd = sd; v.rdata = rdata;
    v.mem_en = mem_en; v.wen = wen; v.msize = msize; v.rd = rd; v.rd_wen = rd_wen;
    v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_wmask = exp_wmask;
    v.exp_wdata = exp_wdata; v.exp_rd_wen = exp_rd_wen; v.exp_out = exp_out;
    v.chk_out = chk_out; v.exp_mis = exp_mis;
    v.req_stall = rs; v.rsp_dly = rdl; v.out_stall = os;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_pc = v.pc; in_result = v.result; in_store_data = v.sd;
    in_mem_en = v.mem_en; in_mem_wen = v.wen; in_mem_size = v.msize;
    in_rd = v.rd; in_rd_wen = v.rd_wen;
    out_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    @(negedge clk);
    in_valid = 0; in_pc = $urandom; in_result = $urandom; in_store_data = $urandom;
    in_rd = 5'($urandom); in_rd_wen = 1'($urandom); in_mem_size = 3'($urandom);
    chk("in_ready_busy", in_ready, 0);
    chk("misalign_pulse", lsu_misalign, v.exp_mis);
    if (v.exp_mem) begin
      for (int i = 0; i <= v.req_stall; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, v.exp_addr);
        chk("req_wen", mem_req_wen, v.wen);
        chk("req_wmask", mem_req_wmask, v.exp_wmask);
        if (v.wen) chk("req_wdata", mem_req_wdata, v.exp_wdata);
        chk("out_valid_req", out_valid, 0);
        if (i == v.req_stall) mem_req_ready = 1;
        @(negedge clk);
      end
      mem_req_ready = 0;
      for (int i = 0; i <= v.rsp_dly; i++) begin
        chk("req_dropped", mem_req_valid, 0);
        chk("out_valid_wait", out_valid, 0);
        if (i == v.rsp_dly) begin mem_rsp_valid = 1; mem_rsp_rdata = v.rdata; end
        @(negedge clk);
      end
      mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
    end else begin
      chk("no_req", mem_req_valid, 0);
    end
    for (int i = 0; i <= v.out_stall; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_pc", out_pc, v.pc);
      chk("out_rd", 32'(out_rd), 32'(v.rd));
      chk("out_rd_wen", out_rd_wen, v.exp_rd_wen);
      if (v.chk_out) chk("out_wdata", out_wdata, v.exp_out);
      chk("in_ready_done", in_ready, 0);
      if (i > 0 || v.exp_mem) chk("misalign_low", lsu_misalign, 0);
      if (i == v.out_stall) out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    chk("out_valid_clr", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 0; in_pc = 0; in_result = 0; in_store_data = 0;
    in_mem_en = 0; in_mem_wen = 0; in_mem_size = 0; in_rd = 0; in_rd_wen = 0;
    out_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;

    tbl[0] = mk(32'h8000_0000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 3'd2, 5'd5, 1,
                0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_1234, 1, 0, 0, 0, 0);
    tbl[1] = mk(32'h8000_0004, 32'h8000_0003, 32'hAABB_CCDD, 32'h0, 1, 1, 3'd0, 5'd7, 1,
                1, 32'h8000_0000, 4'b1000, 32'hDDDD_DDDD, 0, 32'h0, 0, 0, 3, 0, 0);
    tbl[2] = mk(32'h8000_0008, 32'h8000_0101, 32'h0, 32'h0000_8000, 1, 0, 3'd0, 5'd10, 1,
                1, 32'h8000_0100, 4'b0000, 32'h0, 1, 32'hFFFF_FF80, 1, 0, 0, 0, 4);
    tbl[3] = mk(32'h8000_000C, 32'h8000_0202, 32'h0, 32'hBEEF_0000, 1, 0, 3'd5, 5'd11, 1,
                1, 32'h8000_0200, 4'b0000, 32'h0, 1, 32'h0000_BEEF, 1, 0, 0, 2, 0);
    tbl[4] = mk(32'h8000_0010, 32'h0000_1006, 32'h1234_5678, 32'h0, 1, 1, 3'd1, 5'd3, 1,
                1, 32'h0000_1004, 4'b1100, 32'h5678_5678, 0, 32'h0, 0, 0, 1, 1, 1);
    tbl[5] = mk(32'h8000_0014, 32'h0000_2000, 32'hCAFE_BABE, 32'h0, 1, 1, 3'd2, 5'd4, 0,
                1, 32'h0000_2000, 4'b1111, 32'hCAFE_BABE, 0, 32'h0, 0, 0, 0, 0, 0);
    tbl[6] = mk(32'h8000_0018, 32'h0000_3000, 32'h0, 32'h1234_F00D, 1, 0, 3'd1, 5'd12, 1,
                1, 32'h0000_3000, 4'b0000, 32'h0, 1, 32'hFFFF_F00D, 1, 0, 0, 0, 0);
    tbl[7] = mk(32'h8000_001C, 32'h0000_4003, 32'h0, 32'h9A00_0000, 1, 0, 3'd4, 5'd13, 1,
                1, 32'h0000_4000, 4'b0000, 32'h0, 1, 32'h0000_009A, 1, 0, 0, 0, 0);
    tbl[8] = mk(32'h8000_0020, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 1, 0, 3'd3, 5'd14, 1,
                1, 32'h0000_5000, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
`ifdef YSYX_24070016_LSU_MISALIGN_CHECK_EN
    tbl[9] = mk(32'h8000_0024, 32'h8000_0012, 32'h0, 32'h8765_4321, 1, 0, 3'd2, 5'd15, 1,
                0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0);
`else
    tbl[9] = mk(32'h8000_0024, 32'h8000_0012, 32'h0, 32'h8765_4321, 1, 0, 3'd2, 5'd15, 1,
                1, 32'h8000_0010, 4'h0, 32'h0, 1, 32'h8765_4321, 1, 0, 0, 0, 0);
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_wen", mem_req_wen, 0);
    chk("rst_rd_wen", out_rd_wen, 0);
    chk("rst_misalign", lsu_misalign, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_req_wmask", 32'(mem_req_wmask), 0);
    rst_n = 1;

    foreach (tbl[k]) run_vec(tbl[k]);

    // Response coinciding with request acceptance is ignored.
    @(negedge clk);
    in_valid = 1; in_pc = 32'h9000_0000; in_result = 32'h0000_0204; in_mem_en = 1;
    in_mem_wen = 0; in_mem_size = 3'd2; in_rd = 5'd9; in_rd_wen = 1;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 0;
    chk("early_rsp_ignored", out_valid, 0);
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("late_rsp_valid", out_valid, 1);
    chk("late_rsp_data", out_wdata, 32'h2222_2222);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Reset asserted while waiting for a response.
    in_valid = 1; in_pc = 32'h9000_0010; in_result = 32'h0000_0100; in_mem_en = 1;
    in_mem_wen = 0; in_mem_size = 3'd2;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("wait_in_ready", in_ready, 0);
    rst_n = 0;
    #1;
    chk("rstwait_in_ready", in_ready, 1);
    chk("rstwait_out_valid", out_valid, 0);
    chk("rstwait_req_valid", mem_req_valid, 0);
    @(negedge clk);
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h3333_3333;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("stray_rsp_out_valid", out_valid, 0);
    chk("stray_rsp_in_ready", in_ready, 1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      rv.pc = $urandom; rv.result = $urandom; rv.sd = $urandom; rv.rdata = $urandom;
      rv.mem_en = ($urandom_range(0, 3) != 0);
      rv.wen = 1'($urandom);
      rv.rd = 5'($urandom); rv.rd_wen = 1'($urandom);
      if (rv.wen) begin
        case ($urandom_range(0, 4))
          0: rv.msize = 3'd0;
          1: rv.msize = 3'd1;
          2: rv.msize = 3'd2;
          3: rv.msize = 3'd3;
          default: rv.msize = 3'd7;
        endcase
      end else begin
        rv.msize = 3'($urandom);
      end
      rv.req_stall = $urandom_range(0, 2);
      rv.rsp_dly = $urandom_range(0, 2);
      rv.out_stall = $urandom_range(0, 2);
      rv = model(rv);
      run_vec(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24070016_lsu.md
# ysyx_24070016_lsu

Load/store stage directly downstream of the execute stage in the ysyx_24070016 core. It accepts the ALU result (`exu_result`) as a memory address or pass-through value and runs a multi-cycle request/response transaction for loads and stores. It aligns store data into byte lanes and sign/zero-extends load data. It presents one write-back beat per instruction to the write-back stage over a valid/ready handshake.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: execute-stage beat valid.
- `in_ready` output 1: LSU can accept a beat.
- `in_pc` input 32: instruction PC.
- `in_result` input 32: ALU result; the byte address for memory ops, the write-back value otherwise.
- `in_store_data` input 32: rs2 value for stores.
- `in_mem_en` input 1: instruction accesses memory.
- `in_mem_wen` input 1: store when 1, load when 0; meaningful only with `in_mem_en`.
- `in_mem_size` input 3: funct3 encoding 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `in_rd` input 5: destination register index.
- `in_rd_wen` input 1: destination register write enable.
- `out_valid` output 1: write-back beat valid.
- `out_ready` input 1: write-back stage accepts the beat.
- `out_pc` output 32: registered PC.
- `out_rd` output 5: registered destination register index.
- `out_rd_wen` output 1: registered write enable; forced 0 for stores.
- `out_wdata` output 32: load data or pass-through result.
- `mem_req_valid` output 1: memory request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_req_wen` output 1: write request.
- `mem_req_wdata` output 32: lane-shifted store data.
- `mem_req_wmask` output 4: byte-lane enables.
- `mem_rsp_valid` input 1: response beat; exactly one per accepted request, loads and stores alike.
- `mem_rsp_rdata` input 32: read word.
- `lsu_misalign` output 1: one-cycle pulse when a misaligned access is dropped (macro builds only).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` the beat is latched.
  - Next state is REQ if `in_mem_en`, otherwise DONE with `out_wdata`=`in_result`.
- **REQ**
  - `mem_req_valid`=1 with stable addr/wen/wdata/wmask.
  - The request is accepted on `mem_req_valid && mem_req_ready`, then the FSM moves to WAIT.
- **WAIT**
  - Waits for `mem_rsp_valid`.
  - For loads, the selected lanes are captured into `out_wdata` and the FSM moves to DONE.
  - For stores, `rdata` is ignored.
- **DONE**
  - `out_valid`=1 and all `out_*` are held stable until `out_ready`, then the FSM returns to IDLE.
- `in_ready`=1 only in IDLE; there is no overlap between instructions.
- Lane rules use `o`=`addr[1:0]`:
  - B: wmask=`0001<<o`, wdata=`{4{sd[7:0]}}`.
  - H: wmask=`0011<<o`, wdata=`{2{sd[15:0]}}`.
  - W: wmask=`1111`, wdata=`sd`.
  - Loads extract `rdata>>(8*o)`.
  - B and H are sign-extended; BU and HU are zero-extended.
- Loads drive `mem_req_wmask`=0000.
- An unlisted `mem_size` is treated as W.
- A `mem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: FSM IDLE; `in_ready`=1; `out_valid`, `mem_req_valid`, `mem_req_wen`, `out_rd_wen`, `lsu_misalign`=0; `out_pc`, `out_wdata`, `mem_req_addr`, `mem_req_wdata`=0; `out_rd`=0; `mem_req_wmask`=0.
- Non-memory op: accepted at cycle 0, `out_valid` at cycle 1.
- Memory op with zero-wait memory:
  - accepted at cycle 0;
  - `mem_req_valid` in cycle 1, request accepted in cycle 1;
  - response in cycle 2;
  - `out_valid` in cycle 3.
- General memory op: `out_valid` appears one cycle after the `mem_rsp_valid` cycle.
- Once `mem_req_valid` is raised it is not dropped until `mem_req_ready`.
- A response in the same cycle as request acceptance is not legal from memory and is ignored.
- `rst_n` asserted mid-transaction returns the FSM to IDLE immediately; an outstanding memory response is the memory's responsibility to squash.
- All outputs are registered, with no combinational in→out paths except `in_ready`, which is decoded from the state register.

## Configuration
- Macro: `YSYX_24070016_LSU_MISALIGN_CHECK_EN`.
- **Defined:** a misaligned access (H with `o`∈{1,3}, W with `o`≠0) skips REQ/WAIT and goes IDLE→DONE.
  - `out_wdata`=0 and `out_rd_wen`=0.
  - `lsu_misalign` pulses 1 for the cycle DONE is entered.
- **Undefined:** there is no check, and `lsu_misalign` is tied 0.
  - The offset used is H `o&2`, W `0`; the low address bits are effectively truncated.
  - `mem_req_addr` is still `addr` with its low 2 bits cleared.

## Structure
- The package `ysyx_24070016_lsu_pkg` holds:
  - the FSM state typedef (2 bits);
  - the `mem_size` encoding constants (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`).
- One sub-module, `ysyx_24070016_lsu_align`: purely combinational lane logic.
  - Store side: `addr[1:0]`, `size`, `sd` → `wmask`, `wdata`.
  - Load side: `addr[1:0]`, `size`, `rdata` → extended value.

## Test plan
- **Non-memory op:** `in_result`=0x1234, `in_mem_en`=0, `out_ready`=1 → `out_wdata`=0x1234 with `out_valid` at cycle 1 and no `mem_req_valid`.
- **SB:** addr 0x80000003, sd=0xAABBCCDD → `mem_req_addr`=0x80000000, wmask=1000, wdata=0xDDDDDDDD; `out_rd_wen`=0.
- **LB / LHU:**
  - LB at addr 0x...1 with rdata=0x0000_8000 → `out_wdata`=0xFFFFFF80.
  - LHU at `o`=2 with rdata=0xBEEF_0000 → 0x0000BEEF.
- **Backpressure:**
  - `mem_req_ready` low for 3 cycles → request held stable.
  - `out_ready` low for 4 cycles → `out_*` held; `in_ready` stays 0 until the handshake.
- **Reset in WAIT:** `rst_n` low during WAIT → immediately IDLE, `in_ready`=1, `out_valid`=0; a later stray `mem_rsp_valid` is ignored.
- **LW at 0x...2:**
  - With the macro: `lsu_misalign` pulses, no memory request, `out_rd_wen`=0.
  - Without the macro: the request goes to addr 0x...0.
